// File: rtl/ppgen_pkg.sv
// Shared types, widths and the Baugh-Wooley matrix function for the partial-product generator.
package ppgen_pkg;

  localparam int unsigned W          = 8;
  localparam int unsigned PP_W       = W * W;
  localparam bit          SIGNED_DEF = 1'b1;

  typedef logic [PP_W-1:0] pp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sweep_state_t;

  // Row i, column j lands on bit W*i+j; the sign row/column are inverted, the corner bit is not.
  function automatic pp_t bw_matrix(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic signed_en);
    pp_t pp;
    pp = '0;
    for (int unsigned i = 0; i < W; i++) begin
      for (int unsigned j = 0; j < W; j++) begin
        pp[W*i+j] = (a[j] & b[i]) ^ (signed_en & ((i == W-1) ^ (j == W-1)));
      end
    end
    return pp;
  endfunction

endpackage

// File: rtl/pp_bw_array.sv
// Combinational operand pair to partial-product matrix.
module pp_bw_array
  import ppgen_pkg::*;
#(
  parameter bit SIGNED = SIGNED_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output pp_t          pp
);

  // Matrix generation, no state.
  assign pp = bw_matrix(a, b, SIGNED);

endmodule

// File: rtl/ppgen_bw_pipe.sv
// Two-stage elastic pipeline producing the 8x8 Baugh-Wooley partial-product bus.
// Optional exhaustive operand sweep generator enabled by macro PPGEN_SWEEP_EN.
module ppgen_bw_pipe
  import ppgen_pkg::*;
#(
  parameter bit SIGNED = SIGNED_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_a,
  input  logic [W-1:0] s_b,
  output logic         m_valid,
  input  logic         m_ready,
  output pp_t          m_pp,
  output logic [W-1:0] m_a,
  output logic [W-1:0] m_b
`ifdef PPGEN_SWEEP_EN
  ,
  input  logic         sweep_start,
  output logic         sweep_busy,
  output logic         sweep_done
`endif
);

  localparam int unsigned CNT_W = 2 * W;

  logic         v1;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  pp_t          pp1;
  logic         s2_take;
  logic         s1_open;
  logic         in_valid;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;

  // Stage 2 loads when it is empty or being drained; stage 1 opens when empty or moving on.
  assign s2_take = v1 & (~m_valid | m_ready);
  assign s1_open = ~v1 | s2_take;

`ifdef PPGEN_SWEEP_EN
  sweep_state_t     state;
  logic [CNT_W-1:0] cnt;

  // Sweep owns stage 1 while active; the external port is shut off.
  assign in_valid   = (state == SWEEP) ? 1'b1 : s_valid;
  assign in_a       = (state == SWEEP) ? cnt[CNT_W-1:W] : s_a;
  assign in_b       = (state == SWEEP) ? cnt[W-1:0] : s_b;
  assign s_ready    = ~rst & s1_open & (state != SWEEP);
  assign sweep_busy = (state == SWEEP);
  assign sweep_done = (state == DONE);

  // Sweep FSM and operand counter; counter advances only on a stage-1 accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sweep_start) state <= SWEEP;
        end
        SWEEP: begin
          if (s1_open) begin
            if (cnt == {CNT_W{1'b1}}) begin
              state <= DONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign in_valid = s_valid;
  assign in_a     = s_a;
  assign in_b     = s_b;
  assign s_ready  = ~rst & s1_open;
`endif

  // Stage 1: operand register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
    end else if (s1_open) begin
      v1 <= in_valid;
      if (in_valid) begin
        a1 <= in_a;
        b1 <= in_b;
      end
    end
  end

  pp_bw_array #(
    .SIGNED(SIGNED)
  ) u_array (
    .a (a1),
    .b (b1),
    .pp(pp1)
  );

  // Stage 2: matrix plus operands, held while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_pp    <= '0;
      m_a     <= '0;
      m_b     <= '0;
    end else if (~m_valid | m_ready) begin
      m_valid <= v1;
      if (s2_take) begin
        m_pp <= pp1;
        m_a  <= a1;
        m_b  <= b1;
      end
    end
  end

endmodule

// File: tb/tb_ppgen_bw_pipe.sv
// Self-checking bench for ppgen_bw_pipe: directed vectors, stalls, reset and random traffic.
module tb_ppgen_bw_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        u_s_ready;
  logic [7:0]  s_a = 8'h00;
  logic [7:0]  s_b = 8'h00;
  logic        m_valid;
  logic        u_m_valid;
  logic        m_ready = 1'b0;
  logic [63:0] m_pp;
  logic [63:0] u_m_pp;
  logic [7:0]  m_a, m_b, u_m_a, u_m_b;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_out = 0;
  int last_lat = -1;
  logic [63:0] last_pp = '0;
  logic [63:0] last_upp = '0;
  logic        hold_v = 1'b0;
  logic [63:0] hold_pp = '0;
  logic [15:0] hold_ab = '0;
  logic [15:0] exp_q[$];
  int          acc_q[$];

  always #5 clk = ~clk;

  ppgen_bw_pipe #(.SIGNED(1'b1)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .m_valid(m_valid), .m_ready(m_ready), .m_pp(m_pp), .m_a(m_a), .m_b(m_b)
  );

  ppgen_bw_pipe #(.SIGNED(1'b0)) u_uns (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(u_s_ready), .s_a(s_a), .s_b(s_b),
    .m_valid(u_m_valid), .m_ready(m_ready), .m_pp(u_m_pp), .m_a(u_m_a), .m_b(u_m_b)
  );

  // Row-wise reference: row i is a when b[i] is set; signed rows get the sign bits flipped.
  function automatic logic [63:0] model_pp(input logic [7:0] a, input logic [7:0] b, input bit sgn);
    logic [63:0] pp;
    logic [7:0]  row;
    pp = '0;
    for (int i = 0; i < 8; i++) begin
      row = b[i] ? a : 8'h00;
      if (sgn) row = row ^ ((i == 7) ? 8'h7F : 8'h80);
      pp[8*i +: 8] = row;
    end
    return pp;
  endfunction

  // Weighted sum of the matrix plus the compressor's constants, modulo 2^16.
  function automatic int pp_sum(input logic [63:0] pp);
    int s;
    s = 256 + 32768;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (pp[8*i+j]) s += (1 << (i + j));
    return s & 32'hFFFF;
  endfunction

  function automatic int sprod(input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return (sa * sb) & 32'hFFFF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, then observe handshakes before the next rising edge.
  task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b, input logic mr);
    logic [15:0] e;
    int          t;
    @(negedge clk);
    s_valid = v;
    s_a     = a;
    s_b     = b;
    m_ready = mr;
    #1;
    if (hold_v) begin
      chk("stall_valid", 64'(m_valid), 64'd1);
      chk("stall_pp", m_pp, hold_pp);
      chk("stall_ab", 64'({m_a, m_b}), 64'(hold_ab));
    end
    if (s_valid && s_ready) begin
      exp_q.push_back({a, b});
      acc_q.push_back(cyc);
      n_acc++;
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_output", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        t = acc_q.pop_front();
        chk("out_ab", 64'({m_a, m_b}), 64'(e));
        chk("out_pp", m_pp, model_pp(e[15:8], e[7:0], 1'b1));
        chk("out_pp_unsigned", u_m_pp, model_pp(e[15:8], e[7:0], 1'b0));
        chk("out_product", 64'(pp_sum(m_pp)), 64'(sprod(e[15:8], e[7:0])));
        last_lat = cyc - t;
        last_pp  = m_pp;
        last_upp = u_m_pp;
        n_out++;
      end
    end
    hold_v  = m_valid && !m_ready;
    hold_pp = m_pp;
    hold_ab = {m_a, m_b};
    cyc++;
  endtask

  logic [15:0] pairs[8];
  int          base_acc;
  int          base_out;

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_pp", m_pp, 64'd0);
    chk("rst_m_ab", 64'({m_a, m_b}), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_s_ready", 64'(s_ready), 64'd1);

    // Directed vectors with latency check.
    cycle(1'b1, 8'h00, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    chk("lat_00", 64'(last_lat), 64'd2);
    chk("vec_00", last_pp, 64'h7F80_8080_8080_8080);
    cycle(1'b1, 8'hFF, 8'hFF, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    chk("lat_ff", 64'(last_lat), 64'd2);
    chk("vec_ff", last_pp, 64'h807F_7F7F_7F7F_7F7F);
    cycle(1'b1, 8'h01, 8'h01, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    chk("vec_01", last_pp, 64'h7F80_8080_8080_8081);
    chk("vec_01_unsigned", last_upp, 64'h0000_0000_0000_0001);

    // Back-to-back pairs with m_ready pattern 1,0,0,1.
    for (int k = 0; k < 8; k++) pairs[k] = 16'($urandom);
    base_acc = n_acc;
    base_out = n_out;
    for (int k = 0; k < 60 && (n_out - base_out) < 8; k++) begin
      if ((n_acc - base_acc) < 8)
        cycle(1'b1, pairs[n_acc-base_acc][15:8], pairs[n_acc-base_acc][7:0],
              (k % 4 == 0) || (k % 4 == 3));
      else
        cycle(1'b0, 8'h00, 8'h00, (k % 4 == 0) || (k % 4 == 3));
    end
    chk("b2b_count", 64'(n_out - base_out), 64'd8);

    // Full throughput: 4 pairs in 4 consecutive cycles.
    base_acc = n_acc;
    for (int k = 0; k < 4; k++) cycle(1'b1, 8'($urandom), 8'($urandom), 1'b1);
    chk("full_rate", 64'(n_acc - base_acc), 64'd4);
    for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 8'h00, 1'b1);

    // Reset with both stages full.
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    chk("full_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd0);
    exp_q.delete();
    acc_q.delete();
    hold_v = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrel_s_ready", 64'(s_ready), 64'd1);
    chk("midrel_m_valid", 64'(m_valid), 64'd0);

    // Random traffic against the scoreboard.
    for (int k = 0; k < 400; k++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0 && !m_valid) break;
      cycle(1'b0, 8'h00, 8'h00, 1'b1);
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
